instr_fifo: RTL
===============

// Module: instr_fifo
// PURPOSE
//   Parametrised single-clock instruction FIFO between the external instruction interface and the controller.
//   Valid/ready handshakes on both sides; show-ahead (first-word fall-through) output.
//   Adds occupancy count, almost-full flag, flush, and a high-water mark for performance debug.
// PARAMETERS
//   DATA_W       64   instruction word width in bits
//   DEPTH        64   number of entries; power of two, >= 2
//   AFULL_THRESH 56   almost_full asserts when count >= AFULL_THRESH; range 1..DEPTH
//   CNT_W        $clog2(DEPTH+1)   derived; width of the count outputs
// PORTS
//   clk          in   1       single clock for all logic
//   rst          in   1       synchronous active-high reset
//   in_valid     in   1       producer has a word on in_data
//   in_data      in   DATA_W  instruction word to enqueue
//   in_ready     out  1       FIFO can accept a word; equals !full
//   out_valid    out  1       out_data holds the oldest word; equals !empty
//   out_data     out  DATA_W  oldest stored word (show-ahead)
//   out_ready    in   1       controller consumes out_data this cycle
//   flush        in   1       discard all stored words
//   count        out  CNT_W   current occupancy, 0..DEPTH
//   almost_full  out  1       count >= AFULL_THRESH
//   hwm          out  CNT_W   highest count reached since reset or hwm_clr
//   hwm_clr      in   1       clear hwm to the current count
// BEHAVIOUR
//   Clock and reset: single clock domain. rst is sampled on posedge clk and overrides every other input.
//   Reset state: wr_ptr = 0, rd_ptr = 0, count = 0, hwm = 0.
//     Outputs after reset: in_ready = 1, out_valid = 0, almost_full = 0.
//     Storage contents are not reset. out_data is don't-care while out_valid = 0.
//   Push condition: push = in_valid & in_ready.
//     mem[wr_ptr] <= in_data; wr_ptr increments modulo DEPTH (natural wrap, DEPTH - 1 -> 0).
//   Pop condition: pop = out_valid & out_ready.
//     rd_ptr increments modulo DEPTH.
//     out_ready while empty is ignored: no pointer change, no error.
//   Count update: count <= count + push - pop.
//     Simultaneous push and pop leaves count unchanged. Both pointers advance.
//   Latency: a word pushed in cycle N is visible on out_data with out_valid = 1 in cycle N+1.
//     No same-cycle bypass when empty.
//   out_data = mem[rd_ptr]: combinational read of the current read pointer.
//   Full (count == DEPTH):
//     in_ready = 0; in_valid is ignored and in_data is not written; the producer must hold.
//     Pop plus in_valid in the same full cycle: only the pop occurs, count becomes DEPTH-1.
//   Empty (count == 0): out_valid = 0. A push with out_ready = 1 in the same cycle is not popped.
//   Flush: takes effect at the next edge, with priority over push and pop in that cycle (both dropped).
//     wr_ptr = 0, rd_ptr = 0, count = 0; hwm is kept.
//     Priority order: rst > flush > push/pop.
//   High-water mark: hwm <= max(hwm, next_count) every cycle.
//     hwm_clr loads next_count instead. flush with hwm_clr gives hwm = 0.
//   Derived flags: in_ready, out_valid and almost_full are combinational decodes of registered count; no glitch paths from inputs.
//   Reset mid-operation: all words in flight are lost; the next cycle matches the reset state.
// TESTING
//   T1 Reset: rst for 2 cycles with in_valid = 1 -> count = 0, out_valid = 0, in_ready = 1, hwm = 0; nothing enqueued.
//   T2 Ordering and latency: push 0x1111, 0x2222, 0x3333 on consecutive cycles, out_ready = 0.
//      -> out_valid rises 1 cycle after the first push; out_data = 0x1111.
//      -> pop 3 times: read order 0x1111, 0x2222, 0x3333; count returns 0.
//   T3 Full and back-pressure (DEPTH = 64): push 64 words i = 0..63.
//      -> in_ready = 0 and count = 64; almost_full rose when count reached 56.
//      -> 65th word held on in_valid is not lost.
//      -> one pop gives out_data = 0, in_ready = 1; the held word is then accepted.
//   T4 Simultaneous push/pop and wrap-around: with count = 5, run push+pop together for 200 cycles.
//      -> count stays 5; pointers wrap at least 3 times; output equals input delayed by 5 pops.
//   T5 Flush: with count = 10, assert flush together with push and pop.
//      -> next cycle count = 0, out_valid = 0, hwm = 10.
//      -> next push of 0xABCD appears on out_data one cycle later.
//   T6 HWM: fill to 20, drain to 3 -> hwm = 20; hwm_clr -> hwm = 3; push 1 -> hwm = 4.

Source files
------------

// File: rtl/instr_fifo.sv
// ---------------------------------------------------------------------------
// instr_fifo
//
// Single-clock instruction FIFO between the external instruction interface
// and the controller. It uses valid/ready handshakes on both sides and a
// show-ahead (first-word fall-through) read port. It also provides occupancy
// count, almost-full flag, flush, and a high-water mark for performance debug.
//
// Ports
//   clk          in   1       single clock for all logic
//   rst          in   1       synchronous active-high reset (overrides all)
//   in_valid     in   1       producer has a word on in_data
//   in_data      in   DATA_W  instruction word to enqueue
//   in_ready     out  1       FIFO can accept a word (not full)
//   out_valid    out  1       out_data holds the oldest word (not empty)
//   out_data     out  DATA_W  oldest stored word, combinational read
//   out_ready    in   1       controller consumes out_data this cycle
//   flush        in   1       discard all stored words at the next edge
//   count        out  CNT_W   current occupancy, 0..DEPTH
//   almost_full  out  1       count >= AFULL_THRESH
//   hwm          out  CNT_W   highest count since reset or hwm_clr
//   hwm_clr      in   1       load hwm with the next count
// ---------------------------------------------------------------------------
module instr_fifo #(
    parameter int unsigned DATA_W       = 64,
    parameter int unsigned DEPTH        = 64,
    parameter int unsigned AFULL_THRESH = 56,
    parameter int unsigned CNT_W        = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready,
    input  logic              flush,
    output logic [CNT_W-1:0]  count,
    output logic              almost_full,
    output logic [CNT_W-1:0]  hwm,
    input  logic              hwm_clr
);

    // DEPTH is a power of two, so pointers wrap naturally at DEPTH-1 -> 0.
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_AFULL = CNT_W'(AFULL_THRESH);
    localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [PTR_W-1:0] PTR_ZERO  = {PTR_W{1'b0}};
    localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);

    // Larger of two occupancy values.
    function automatic logic [CNT_W-1:0] cnt_max(
        input logic [CNT_W-1:0] a,
        input logic [CNT_W-1:0] b
    );
        cnt_max = (a > b) ? a : b;
    endfunction

    // Storage (intentionally not reset) and state registers.
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q,  count_d;
    logic [CNT_W-1:0]  hwm_q,    hwm_d;

    logic full_s;
    logic empty_s;
    logic push_s;
    logic pop_s;

    // Flags are decodes of the registered count only, so no input reaches
    // in_ready/out_valid combinationally.
    assign full_s      = (count_q == CNT_FULL);
    assign empty_s     = (count_q == CNT_ZERO);
    assign in_ready    = ~full_s;
    assign out_valid   = ~empty_s;
    assign almost_full = (count_q >= CNT_AFULL);
    assign count       = count_q;
    assign hwm         = hwm_q;

    // Show-ahead read: head of the queue is always on out_data.
    assign out_data = mem_q[rd_ptr_q];

    // A push while full and a pop while empty are both suppressed here.
    assign push_s = in_valid & in_ready;
    assign pop_s  = out_valid & out_ready;

    // Next-state for pointers and count; flush wins over push and pop.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = PTR_ZERO;
            rd_ptr_d = PTR_ZERO;
            count_d  = CNT_ZERO;
        end else begin
            if (push_s) begin
                wr_ptr_d = wr_ptr_q + PTR_ONE;
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (pop_s) begin
                rd_ptr_d = rd_ptr_q + PTR_ONE;
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            case ({push_s, pop_s})
                2'b10:   count_d = count_q + CNT_ONE;
                2'b01:   count_d = count_q - CNT_ONE;
                default: count_d = count_q;
            endcase
        end
    end

    // High-water mark tracks the occupancy that will be visible next cycle;
    // a clear restarts tracking from that occupancy (0 when flushing).
    always_comb begin
        hwm_d = hwm_q;
        if (hwm_clr) begin
            hwm_d = count_d;
        end else begin
            hwm_d = cnt_max(hwm_q, count_d);
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= PTR_ZERO;
            rd_ptr_q <= PTR_ZERO;
            count_q  <= CNT_ZERO;
            hwm_q    <= CNT_ZERO;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            hwm_q    <= hwm_d;
        end
    end

    // Storage write; a push dropped by reset or flush must not write either.
    always_ff @(posedge clk) begin
        if (push_s && !flush && !rst) begin
            mem_q[wr_ptr_q] <= in_data;
        end
    end

endmodule
